// File: rtl/assert_implication_monitor.sv
// -----------------------------------------------------------------------------
// assert_implication_monitor
//
// Monitors the property "antecedent |-> ##DELAY consequent" with overlapping
// obligations. Every cycle in which en_i & antecedent_i is sampled launches an
// obligation. That obligation is checked exactly once, DELAY cycles later,
// against consequent_i. Also keeps sticky failure state, saturating pass/fail
// statistics and the cycle number of the first failure.
//
// Parameters
//   DELAY  cycles from antecedent sample to consequent check (1..64)
//   CNT_W  width of the pass/fail statistics counters
//   CYC_W  width of the free-running cycle counter and first_fail_cyc_o
//
// Ports
//   clk_i             clock, posedge
//   rst_i             synchronous active-high reset, highest priority
//   en_i              gates the launch of new obligations only
//   clear_i           synchronous clear of the statistics
//   antecedent_i      property antecedent term
//   consequent_i      property consequent term
//   valid_o           1 = no failure this cycle (combinational)
//   fail_o            failure strobe this cycle (combinational, ~valid_o)
//   pass_o            matured obligation held this cycle (combinational)
//   fail_sticky_o     set on first failure, cleared by rst_i or clear_i
//   fail_count_o      saturating failure count
//   pass_count_o      saturating pass count
//   first_fail_cyc_o  cycle counter value at the first failure
//   pending_o         at least one obligation in flight
// -----------------------------------------------------------------------------
module assert_implication_monitor #(
  parameter int unsigned DELAY = 1,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             antecedent_i,
  input  logic             consequent_i,
  output logic             valid_o,
  output logic             fail_o,
  output logic             pass_o,
  output logic             fail_sticky_o,
  output logic [CNT_W-1:0] fail_count_o,
  output logic [CNT_W-1:0] pass_count_o,
  output logic [CYC_W-1:0] first_fail_cyc_o,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

  // Obligation pipeline: bit i holds an obligation launched i+1 cycles ago.
  logic [DELAY-1:0] ob_q, ob_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic [CNT_W-1:0] pass_count_q, pass_count_d;
  logic [CYC_W-1:0] first_fail_cyc_q, first_fail_cyc_d;
  logic             fail_sticky_q, fail_sticky_d;

  logic sample_s;
  logic matured_s;
  logic pass_s;
  logic fail_s;

  assign sample_s  = en_i & antecedent_i;
  assign matured_s = ob_q[DELAY-1];
  assign pass_s    = matured_s & consequent_i;
  assign fail_s    = matured_s & ~consequent_i;

  assign valid_o          = ~fail_s;
  assign fail_o           = fail_s;
  assign pass_o           = pass_s;
  assign pending_o        = |ob_q;
  assign fail_sticky_o    = fail_sticky_q;
  assign fail_count_o     = fail_count_q;
  assign pass_count_o     = pass_count_q;
  assign first_fail_cyc_o = first_fail_cyc_q;

  // A one-deep pipeline has no older stages to shift, so it is just the sample.
  generate
    if (DELAY == 1) begin : g_ob_single
      assign ob_d = sample_s;
    end else begin : g_ob_multi
      assign ob_d = {ob_q[DELAY-2:0], sample_s};
    end
  endgenerate

  // Next-state for the cycle counter and the statistics.
  always_comb begin
    cyc_d            = cyc_q;
    fail_count_d     = fail_count_q;
    pass_count_d     = pass_count_q;
    first_fail_cyc_d = first_fail_cyc_q;
    fail_sticky_d    = fail_sticky_q;

    if (cyc_q != CYC_MAX) begin
      cyc_d = cyc_q + CYC_W'(1);
    end else begin
      cyc_d = cyc_q;
    end

    // clear wins over a same-cycle check; the strobes above still show it.
    if (clear_i) begin
      fail_count_d     = '0;
      pass_count_d     = '0;
      first_fail_cyc_d = '0;
      fail_sticky_d    = 1'b0;
    end else begin
      if (fail_s && (fail_count_q != CNT_MAX)) begin
        fail_count_d = fail_count_q + CNT_W'(1);
      end else begin
        fail_count_d = fail_count_q;
      end

      // Only the first failure since reset/clear records its timestamp.
      if (fail_s && !fail_sticky_q) begin
        fail_sticky_d    = 1'b1;
        first_fail_cyc_d = cyc_q;
      end else begin
        fail_sticky_d    = fail_sticky_q;
        first_fail_cyc_d = first_fail_cyc_q;
      end

      if (pass_s && (pass_count_q != CNT_MAX)) begin
        pass_count_d = pass_count_q + CNT_W'(1);
      end else begin
        pass_count_d = pass_count_q;
      end
    end
  end

  // State registers; reset also discards every in-flight obligation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ob_q             <= '0;
      cyc_q            <= '0;
      fail_count_q     <= '0;
      pass_count_q     <= '0;
      first_fail_cyc_q <= '0;
      fail_sticky_q    <= 1'b0;
    end else begin
      ob_q             <= ob_d;
      cyc_q            <= cyc_d;
      fail_count_q     <= fail_count_d;
      pass_count_q     <= pass_count_d;
      first_fail_cyc_q <= first_fail_cyc_d;
      fail_sticky_q    <= fail_sticky_d;
    end
  end

endmodule

// File: tb/tb_assert_implication_monitor.sv
// -----------------------------------------------------------------------------
// Bench for assert_implication_monitor. Three instances share one stimulus
// stream: (DELAY=1, CNT_W=8, CYC_W=16), (DELAY=3, CNT_W=2, CYC_W=16) and
// (DELAY=4, CNT_W=8, CYC_W=4). The model records which cycles launched an
// obligation and when reset last occurred, and derives every output from that
// history. A few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_assert_implication_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, clr, ant, cons;

  logic       v0, f0, p0, st0, pd0;
  logic [7:0] fc0, pc0;
  logic [15:0] ff0;
  logic       v1, f1, p1, st1, pd1;
  logic [1:0] fc1, pc1;
  logic [15:0] ff1;
  logic       v2, f2, p2, st2, pd2;
  logic [7:0] fc2, pc2;
  logic [3:0] ff2;

  assert_implication_monitor #(.DELAY(1), .CNT_W(8), .CYC_W(16)) u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr),
    .antecedent_i(ant), .consequent_i(cons),
    .valid_o(v0), .fail_o(f0), .pass_o(p0), .fail_sticky_o(st0),
    .fail_count_o(fc0), .pass_count_o(pc0), .first_fail_cyc_o(ff0),
    .pending_o(pd0));

  assert_implication_monitor #(.DELAY(3), .CNT_W(2), .CYC_W(16)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr),
    .antecedent_i(ant), .consequent_i(cons),
    .valid_o(v1), .fail_o(f1), .pass_o(p1), .fail_sticky_o(st1),
    .fail_count_o(fc1), .pass_count_o(pc1), .first_fail_cyc_o(ff1),
    .pending_o(pd1));

  assert_implication_monitor #(.DELAY(4), .CNT_W(8), .CYC_W(4)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr),
    .antecedent_i(ant), .consequent_i(cons),
    .valid_o(v2), .fail_o(f2), .pass_o(p2), .fail_sticky_o(st2),
    .fail_count_o(fc2), .pass_count_o(pc2), .first_fail_cyc_o(ff2),
    .pending_o(pd2));

  int dly  [3] = '{1, 3, 4};
  int cmax [3] = '{255, 3, 255};
  int ymax [3] = '{65535, 65535, 15};

  // Model history: which cycles launched an obligation, last reset cycle.
  int cur      = 0;
  int last_rst = -1;
  bit amark [0:63];
  int m_fc [3];
  int m_pc [3];
  int m_ff [3];
  bit m_st [3];

  int errors = 0;
  int checks = 0;

  function automatic bit matured(int k, int c);
    int s;
    s = c - dly[k];
    return (s >= 0) && (s > last_rst) && amark[s];
  endfunction

  function automatic bit pend_exp(int k, int c);
    bit r;
    r = 1'b0;
    for (int s = c - dly[k]; s < c; s++) begin
      if (s >= 0 && s > last_rst && amark[s]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic int cycv(int k, int c);
    int v;
    v = c - last_rst - 1;
    return (v > ymax[k]) ? ymax[k] : v;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cycle=%0d got=%0d expected=%0d",
               name, k, cur, act, exp);
    end
  endtask

  // Model update at each active edge, using the inputs of the ending cycle.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit m, f, p;
      m = matured(k, cur);
      f = m && !cons;
      p = m && cons;
      if (rst || clr) begin
        m_fc[k] = 0; m_pc[k] = 0; m_ff[k] = 0; m_st[k] = 1'b0;
      end else begin
        if (f && m_fc[k] < cmax[k]) m_fc[k] = m_fc[k] + 1;
        if (f && !m_st[k]) begin
          m_st[k] = 1'b1;
          m_ff[k] = cycv(k, cur);
        end
        if (p && m_pc[k] < cmax[k]) m_pc[k] = m_pc[k] + 1;
      end
    end
    if (rst) begin
      last_rst    = cur;
      amark[cur]  = 1'b0;
    end else begin
      amark[cur]  = en && ant;
    end
    cur = cur + 1;
  end

  logic        g_v [3], g_f [3], g_p [3], g_st [3], g_pd [3];
  logic [31:0] g_fc [3], g_pc [3], g_ff [3];

  // Single compare process: model checks every cycle plus literal pins.
  always @(negedge clk) begin
    if (cur >= 1) begin
      g_v[0] = v0; g_f[0] = f0; g_p[0] = p0; g_st[0] = st0; g_pd[0] = pd0;
      g_fc[0] = {24'd0, fc0}; g_pc[0] = {24'd0, pc0}; g_ff[0] = {16'd0, ff0};
      g_v[1] = v1; g_f[1] = f1; g_p[1] = p1; g_st[1] = st1; g_pd[1] = pd1;
      g_fc[1] = {30'd0, fc1}; g_pc[1] = {30'd0, pc1}; g_ff[1] = {16'd0, ff1};
      g_v[2] = v2; g_f[2] = f2; g_p[2] = p2; g_st[2] = st2; g_pd[2] = pd2;
      g_fc[2] = {24'd0, fc2}; g_pc[2] = {24'd0, pc2}; g_ff[2] = {28'd0, ff2};
      for (int k = 0; k < 3; k++) begin
        bit m;
        m = matured(k, cur);
        chk("valid",   k, {31'd0, g_v[k]},  {31'd0, !(m && !cons)});
        chk("fail",    k, {31'd0, g_f[k]},  {31'd0, (m && !cons)});
        chk("pass",    k, {31'd0, g_p[k]},  {31'd0, (m && cons)});
        chk("pending", k, {31'd0, g_pd[k]}, {31'd0, pend_exp(k, cur)});
        chk("sticky",  k, {31'd0, g_st[k]}, {31'd0, m_st[k]});
        chk("fail_count", k, g_fc[k], m_fc[k]);
        chk("pass_count", k, g_pc[k], m_pc[k]);
        chk("first_fail", k, g_ff[k], m_ff[k]);
      end
      case (cur)
        2: begin
          chk("lit_rst_valid", 0, {31'd0, v0}, 32'd1);
          chk("lit_rst_pending", 2, {31'd0, pd2}, 32'd0);
          chk("lit_rst_fcount", 0, {24'd0, fc0}, 32'd0);
        end
        7: begin
          chk("lit_pass_count", 0, {24'd0, pc0}, 32'd1);
          chk("lit_pass_count", 2, {24'd0, pc2}, 32'd1);
          chk("lit_pending", 2, {31'd0, pd2}, 32'd0);
        end
        13: begin
          chk("lit_fail_count", 1, {30'd0, fc1}, 32'd1);
          chk("lit_pass_count", 1, {30'd0, pc1}, 32'd2);
          chk("lit_first_fail", 1, {16'd0, ff1}, 32'd8);
          chk("lit_first_fail", 0, {16'd0, ff0}, 32'd6);
        end
        30: begin
          chk("lit_fail_sat", 1, {30'd0, fc1}, 32'd3);
          chk("lit_sticky", 1, {31'd0, st1}, 32'd1);
          chk("lit_first_hold", 1, {16'd0, ff1}, 32'd8);
        end
        31: chk("lit_fail_strobe_clr", 0, {31'd0, f0}, 32'd1);
        32: begin
          chk("lit_clr_fcount", 0, {24'd0, fc0}, 32'd0);
          chk("lit_clr_sticky", 0, {31'd0, st0}, 32'd0);
          chk("lit_clr_first", 0, {16'd0, ff0}, 32'd0);
        end
        34: chk("lit_recapture", 1, {16'd0, ff1}, 32'd31);
        35: chk("lit_cyc_sat", 2, {28'd0, ff2}, 32'd15);
        38: begin
          chk("lit_rst_mid_pending", 2, {31'd0, pd2}, 32'd0);
          chk("lit_rst_mid_fcount", 2, {24'd0, fc2}, 32'd0);
        end
        default: ;
      endcase
    end
  end

  // Stimulus: {rst, en, clear, antecedent, consequent} per cycle.
  logic [4:0] vec [50] = '{
    5'b10000, 5'b10000, 5'b01010, 5'b01001, 5'b01001,   //  0- 4
    5'b01001, 5'b01001, 5'b01010, 5'b01010, 5'b01001,   //  5- 9
    5'b01000, 5'b01001, 5'b01000, 5'b00000, 5'b01010,   // 10-14
    5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000,   // 15-19
    5'b00000, 5'b01010, 5'b01010, 5'b01010, 5'b01010,   // 20-24
    5'b01010, 5'b00000, 5'b00000, 5'b00000, 5'b00000,   // 25-29
    5'b01010, 5'b00100, 5'b00000, 5'b00000, 5'b00000,   // 30-34
    5'b01010, 5'b01010, 5'b11010, 5'b00000, 5'b00000,   // 35-39
    5'b00000, 5'b00000, 5'b00000, 5'b01011, 5'b01011,   // 40-44
    5'b01011, 5'b00001, 5'b00000, 5'b00000, 5'b00000    // 45-49
  };

  initial begin
    for (int i = 0; i < 50; i++) begin
      {rst, en, clr, ant, cons} = vec[i];
      @(posedge clk);
      #1;
    end
    #10;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/assert_implication_monitor.md
Name: assert_implication_monitor

Overview:
- Parametrised successor to the single-cycle assertion checker: monitors the property "antecedent |-> ##DELAY consequent" over DELAY cycles, with overlapping obligations allowed.
- Adds per-cycle pass/fail strobes, sticky failure, saturating pass/fail statistics, first-failure timestamp and a pending-obligation indicator.
- Sits beside the design under test and is fed by combinational property terms, for example "ena" and "count < 5".
- Intended for both simulation and formal use.

Parameters:
- DELAY, 1: cycles from antecedent sample to consequent check. Legal range is 1..64; DELAY=1 gives the "|=>" form.
- CNT_W, 8: width of fail_count and pass_count.
- CYC_W, 16: width of the internal cycle counter and of first_fail_cyc.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  monitor enable; gates sampling of new antecedents only.
- clear  in  1  synchronous statistics clear.
- antecedent  in  1  property antecedent term.
- consequent  in  1  property consequent term.
- valid  out  1  1 = no failure detected this cycle (combinational from registered state and consequent).
- fail  out  1  failure strobe for this cycle (combinational, equal to ~valid).
- pass  out  1  obligation matured and held this cycle (combinational).
- fail_sticky  out  1  set on first failure; cleared by rst or clear.
- fail_count  out  CNT_W  failures since reset/clear; saturates at all-ones.
- pass_count  out  CNT_W  passes since reset/clear; saturates at all-ones.
- first_fail_cyc  out  CYC_W  cycle-counter value at the first failure; 0 until a failure occurs.
- pending  out  1  at least one obligation is in flight.

Behaviour:
- Obligation pipeline: DELAY-bit shift register ob[DELAY-1:0], shifting each cycle.
  - ob[0] <= en & antecedent.
  - ob[i] <= ob[i-1].
  - The matured obligation m = ob[DELAY-1] is due in the current cycle.
- Check: pass = m & consequent; fail = m & ~consequent; valid = ~fail.
  - With no matured obligation, valid=1 regardless of consequent (vacuous pass); pass is not asserted.
- Overlap: antecedent high on consecutive cycles creates independent obligations, each checked exactly once at its own t+DELAY.
- en low stops new obligations only. Obligations already in flight still mature and are checked.
- pending = |ob.
- Cycle counter cyc: increments every cycle after reset and saturates at all-ones. It is not affected by clear.
- On fail, evaluated at the clock edge:
  - fail_count increments unless saturated.
  - If fail_sticky is 0: fail_sticky <= 1 and first_fail_cyc <= cyc.
- On pass: pass_count increments unless saturated.
- clear, synchronous:
  - fail_count, pass_count, fail_sticky and first_fail_cyc go to 0.
  - ob and cyc are untouched.
  - clear has priority over a same-cycle fail or pass for statistics. The combinational fail/pass strobes still reflect that cycle.
- rst, synchronous, highest priority: ob, cyc, counters, fail_sticky and first_fail_cyc go to 0.
  - Result after rst: valid=1, fail=0, pass=0, pending=0.
  - Reset mid-operation discards all in-flight obligations; none are checked later.
  - Antecedent sampled in the rst cycle is ignored.
- Width rules: counters are unsigned. Saturation compares against all-ones of the respective width; there is no wrap-around.

Test Plan:
- DELAY=1: rst 2 cycles, then en=1, antecedent=1 at cycle 3, consequent=1 at cycle 4 -> pass=1 at cycle 4, pass_count=1, fail_sticky=0, valid=1 throughout.
- DELAY=3: antecedent pulses at cycles 10 and 11, consequent=0 at 13 and 1 at 14 -> fail only at 13, pass at 14, fail_count=1, pass_count=1, first_fail_cyc=13, pending=0 from cycle 15.
- DELAY=2: antecedent=1 at cycle 5, en dropped at cycle 6, consequent=0 at 7 -> fail=1 at 7. Antecedent with en=0 at cycle 8 -> no check at 10, valid=1.
- CNT_W=2: five consecutive failing obligations -> fail_count reads 1,2,3,3,3; fail_sticky=1; first_fail_cyc holds the first failure cycle.
- rst asserted while 2 obligations are pending (DELAY=4) -> pending=0 next cycle, no fail at the original due cycles with consequent=0, all counters 0.
- clear in the same cycle as a fail -> fail=1 that cycle; next cycle fail_count=0, fail_sticky=0, first_fail_cyc=0. A later failure re-captures first_fail_cyc.
